// File: rtl/cfg_frame_writer_if.sv
// Bitstream word stream handshake between a loader (master) and cfg_frame_writer (slave).
interface cfg_frame_writer_if;
    logic [31:0] WordIn;
    logic        WordValid;
    logic        WordReady;

    modport master (output WordIn, output WordValid, input WordReady);
    modport slave  (input WordIn, input WordValid, output WordReady);
endinterface

// File: rtl/cfg_frame_writer.sv
// Configuration frame writer: sync/header/data stream into FrameData + one FrameStrobe pulse.
// Optional trailing checksum word enabled by defining CFG_FRAME_CHECKSUM_EN.
module cfg_frame_writer #(
    parameter int          NumRows         = 4,
    parameter int          NumColumns      = 4,
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter int          StrobeCycles    = 2,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                                  UserCLK,
    input  logic                                  Reset,
    cfg_frame_writer_if.slave                     word_if,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  Synced,
    output logic                                  Busy,
    output logic                                  Err,
    output logic [15:0]                           FramesWritten
);

    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int ColW = (NumColumns > 1) ? $clog2(NumColumns) : 1;
    localparam int FrmW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int IdxW = (NumColumns*MaxFramesPerCol > 1) ? $clog2(NumColumns*MaxFramesPerCol) : 1;
    localparam int StbW = $clog2(StrobeCycles + 1);
    localparam logic [7:0] ColLimit = 8'(NumColumns);
    localparam logic [7:0] FrmLimit = 8'(MaxFramesPerCol);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, STROBE} state_t;

    state_t                             state_q, state_d;
    logic [RowW-1:0]                    rowcnt_q, rowcnt_d;
    logic [ColW-1:0]                    col_q, col_d;
    logic [FrmW-1:0]                    frame_q, frame_d;
    logic [StbW-1:0]                    stb_cnt_q, stb_cnt_d;
    logic [NumRows*FrameBitsPerRow-1:0] data_q, data_d;
    logic                               synced_q, synced_d;
    logic                               err_q, err_d;
    logic [15:0]                        fw_q, fw_d;
`ifdef CFG_FRAME_CHECKSUM_EN
    logic [31:0]                        chk_q, chk_d;
`endif

    logic            word_ready;
    logic            xfer;
    logic [3:0]      hdr_op;
    logic [7:0]      hdr_col;
    logic [7:0]      hdr_frame;
    logic [IdxW-1:0] sel_idx;

    assign word_ready = (state_q != STROBE);
    assign xfer       = word_if.WordValid & word_ready;
    assign hdr_op     = word_if.WordIn[31:28];
    assign hdr_col    = word_if.WordIn[27:20];
    assign hdr_frame  = word_if.WordIn[19:12];
    assign sel_idx    = IdxW'(col_q) * IdxW'(MaxFramesPerCol) + IdxW'(frame_q);

    always_comb begin
        state_d   = state_q;
        rowcnt_d  = rowcnt_q;
        col_d     = col_q;
        frame_d   = frame_q;
        stb_cnt_d = stb_cnt_q;
        data_d    = data_q;
        synced_d  = synced_q;
        err_d     = 1'b0;
        fw_d      = fw_q;
`ifdef CFG_FRAME_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (xfer && word_if.WordIn == SyncWord) begin
                    state_d  = HDR;
                    synced_d = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    if (hdr_op == 4'h1 && hdr_col < ColLimit && hdr_frame < FrmLimit) begin
                        col_d    = hdr_col[ColW-1:0];
                        frame_d  = hdr_frame[FrmW-1:0];
                        rowcnt_d = '0;
                        state_d  = DATA;
`ifdef CFG_FRAME_CHECKSUM_EN
                        chk_d    = word_if.WordIn;
`endif
                    end else if (hdr_op == 4'hF) begin
                        state_d  = IDLE;
                        synced_d = 1'b0;
                    end else begin
                        err_d    = 1'b1;
                        state_d  = IDLE;
                        synced_d = 1'b0;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    data_d[rowcnt_q*FrameBitsPerRow +: FrameBitsPerRow] = word_if.WordIn;
                    rowcnt_d = rowcnt_q + RowW'(1);
`ifdef CFG_FRAME_CHECKSUM_EN
                    chk_d    = chk_q ^ word_if.WordIn;
`endif
                    if (rowcnt_q == RowW'(NumRows - 1)) begin
                        stb_cnt_d = StbW'(StrobeCycles);
`ifdef CFG_FRAME_CHECKSUM_EN
                        state_d   = CHK;
`else
                        state_d   = STROBE;
`endif
                    end
                end
            end
`ifdef CFG_FRAME_CHECKSUM_EN
            CHK: begin
                // A bad checksum abandons the frame but keeps the session synced.
                if (xfer) begin
                    if (word_if.WordIn == chk_q) begin
                        stb_cnt_d = StbW'(StrobeCycles);
                        state_d   = STROBE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HDR;
                    end
                end
            end
`endif
            STROBE: begin
                stb_cnt_d = stb_cnt_q - StbW'(1);
                if (stb_cnt_q == StbW'(1)) begin
                    state_d = HDR;
                    fw_d    = fw_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            rowcnt_q  <= '0;
            col_q     <= '0;
            frame_q   <= '0;
            stb_cnt_q <= '0;
            data_q    <= '0;
            synced_q  <= 1'b0;
            err_q     <= 1'b0;
            fw_q      <= '0;
`ifdef CFG_FRAME_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rowcnt_q  <= rowcnt_d;
            col_q     <= col_d;
            frame_q   <= frame_d;
            stb_cnt_q <= stb_cnt_d;
            data_q    <= data_d;
            synced_q  <= synced_d;
            err_q     <= err_d;
            fw_q      <= fw_d;
`ifdef CFG_FRAME_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    // Strobe decodes straight from the async-reset state, so Reset drops it without a clock.
    always_comb begin
        FrameStrobe = '0;
        if (state_q == STROBE) FrameStrobe[sel_idx] = 1'b1;
    end

    assign word_if.WordReady = word_ready;
    assign FrameData         = data_q;
    assign Synced            = synced_q;
    assign Busy              = (state_q == DATA) || (state_q == STROBE);
    assign Err               = err_q;
    assign FramesWritten     = fw_q;

endmodule

// File: tb/tb_cfg_frame_writer.sv
// Self-checking bench for cfg_frame_writer: directed scenarios plus randomized word stream
// checked every cycle against a word-level behavioural model.
module tb_cfg_frame_writer;
    localparam int          NR   = 4;
    localparam int          NC   = 4;
    localparam int          FB   = 32;
    localparam int          MF   = 20;
    localparam int          SC   = 2;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cfg_frame_writer_if wif();
    logic [NR*FB-1:0] frame_data;
    logic [NC*MF-1:0] frame_strobe;
    logic             synced, busy, err;
    logic [15:0]      fw;

    cfg_frame_writer #(
        .NumRows(NR), .NumColumns(NC), .FrameBitsPerRow(FB),
        .MaxFramesPerCol(MF), .StrobeCycles(SC), .SyncWord(SYNC)
    ) dut (
        .UserCLK(clk), .Reset(rst), .word_if(wif.slave),
        .FrameData(frame_data), .FrameStrobe(frame_strobe),
        .Synced(synced), .Busy(busy), .Err(err), .FramesWritten(fw)
    );

    int checks = 0;
    int errors = 0;
    int prints = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (prints < 40) begin
                prints++;
                $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
            end
        end
    endtask

    // Word-level model: tracks what the stream means, not how the writer sequences it.
    bit          m_synced;
    int          m_rows_left;
    bit          m_chk_wait;
    int          m_strobe_left;
    bit          m_err;
    logic [15:0] m_fw;
    logic [31:0] m_data [NR];
    logic [31:0] m_x;
    int          m_col, m_frame;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_synced = 0; m_rows_left = 0; m_chk_wait = 0; m_strobe_left = 0;
            m_err = 0; m_fw = '0; m_x = '0; m_col = 0; m_frame = 0;
            for (int i = 0; i < NR; i++) m_data[i] = '0;
        end else begin
            m_err = 0;
            if (m_strobe_left > 0) begin
                m_strobe_left--;
                if (m_strobe_left == 0) m_fw++;
            end else if (wif.WordValid) begin
                logic [31:0] w;
                int op, c, f;
                w = wif.WordIn;
                op = int'(w[31:28]); c = int'(w[27:20]); f = int'(w[19:12]);
                if (!m_synced) begin
                    if (w == SYNC) m_synced = 1;
                end else if (m_rows_left > 0) begin
                    m_data[NR - m_rows_left] = w;
                    m_x ^= w;
                    m_rows_left--;
                    if (m_rows_left == 0) begin
`ifdef CFG_FRAME_CHECKSUM_EN
                        m_chk_wait = 1;
`else
                        m_strobe_left = SC;
`endif
                    end
                end else if (m_chk_wait) begin
                    m_chk_wait = 0;
                    if (w == m_x) m_strobe_left = SC;
                    else m_err = 1;
                end else if (op == 1 && c < NC && f < MF) begin
                    m_col = c; m_frame = f; m_rows_left = NR; m_x = w;
                end else if (op == 15) begin
                    m_synced = 0;
                end else begin
                    m_synced = 0; m_err = 1;
                end
            end
        end
    end

    int s45 = 0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [NC*MF-1:0] e_strobe;
            logic [NR*FB-1:0] e_data;
            e_strobe = '0;
            if (m_strobe_left > 0) e_strobe[m_col*MF + m_frame] = 1'b1;
            for (int i = 0; i < NR; i++) e_data[i*FB +: FB] = m_data[i];
            check("ready",  128'(wif.WordReady), 128'(m_strobe_left == 0));
            check("synced", 128'(synced), 128'(m_synced));
            check("busy",   128'(busy), 128'(m_rows_left > 0 || m_strobe_left > 0));
            check("err",    128'(err), 128'(m_err));
            check("fw",     128'(fw), 128'(m_fw));
            check("data",   128'(frame_data), 128'(e_data));
            check("strobe", 128'(frame_strobe), 128'(e_strobe));
            if (frame_strobe[45]) s45++;
        end
    end

    task automatic send(input logic [31:0] w);
        bit acc;
        int n;
        wif.WordIn = w;
        wif.WordValid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = wif.WordReady;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout word=%h not accepted within 50 cycles", w);
        end
    endtask

    task automatic idle(input int n);
        wif.WordValid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] rows [NR];

    task automatic send_frame(input logic [31:0] hdr, input bit good_chk);
        logic [31:0] x;
        x = hdr;
        send(hdr);
        for (int i = 0; i < NR; i++) begin
            send(rows[i]);
            x ^= rows[i];
        end
`ifdef CFG_FRAME_CHECKSUM_EN
        send(good_chk ? x : (x ^ 32'h0000_0100));
`else
        if (!good_chk) x = '0;
`endif
    endtask

    task automatic rand_rows;
        for (int i = 0; i < NR; i++) rows[i] = $urandom;
    endtask

    initial begin
        rst = 1'b1;
        wif.WordValid = 1'b0;
        wif.WordIn = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        check("rst_ready",  128'(wif.WordReady), 128'(1));
        check("rst_synced", 128'(synced), 128'(0));
        check("rst_busy",   128'(busy), 128'(0));
        check("rst_data",   128'(frame_data), 128'(0));
        check("rst_strobe", 128'(frame_strobe), 128'(0));
        check("rst_fw",     128'(fw), 128'(0));

        // unsynced words discarded silently
        send(32'hDEADBEEF);
        send(32'h1020_5000);
        idle(1);
        check("unsync_err",    128'(err), 128'(0));
        check("unsync_synced", 128'(synced), 128'(0));
        check("unsync_strobe", 128'(frame_strobe), 128'(0));

        // basic frame to col2/frame5 -> bit 45
        send(SYNC);
        rows[0] = 32'h11111111; rows[1] = 32'h22222222;
        rows[2] = 32'h33333333; rows[3] = 32'h44444444;
        s45 = 0;
        send_frame(32'h1020_5000, 1);
        wif.WordValid = 1'b0;
        check("f1_strobe_c1", 128'(frame_strobe), 128'(1) << 45);
        check("f1_ready_c1",  128'(wif.WordReady), 128'(0));
        @(posedge clk); #1;
        check("f1_strobe_c2", 128'(frame_strobe), 128'(1) << 45);
        check("f1_ready_c2",  128'(wif.WordReady), 128'(0));
        idle(3);
        check("f1_s45_cycles", 128'(s45), 128'(2));
        check("f1_data", 128'(frame_data), 128'h44444444_33333333_22222222_11111111);
        check("f1_fw",   128'(fw), 128'(1));
        check("model_fw_pin",    128'(m_fw), 128'(1));
        check("model_data_pin",  128'(m_data[2]), 128'h33333333);
        check("f1_strobe_after", 128'(frame_strobe), 128'(0));

        // out-of-range column header
        send(32'h1040_0000);
        check("badcol_err",    128'(err), 128'(1));
        check("badcol_synced", 128'(synced), 128'(0));
        idle(1);
        check("badcol_err_pulse", 128'(err), 128'(0));
        send(32'h1234_5678);
        idle(1);
        check("badcol_data_ignored", 128'(busy), 128'(0));
        check("badcol_still_unsync", 128'(synced), 128'(0));

        // back-to-back frames, valid held high
        send(SYNC);
        rand_rows();
        send_frame(32'h1001_3000, 1);
        check("b2b_strobe19", 128'(frame_strobe), 128'(1) << 19);
        rand_rows();
        send_frame(32'h1030_0000, 1);
        check("b2b_strobe60", 128'(frame_strobe), 128'(1) << 60);
        send(32'hF000_0000);
        check("desync_synced", 128'(synced), 128'(0));
        check("b2b_fw", 128'(fw), 128'(3));
        idle(2);

        // reset during first strobe cycle
        send(SYNC);
        rand_rows();
        send_frame(32'h1020_5000, 1);
        wif.WordValid = 1'b0;
        check("mid_strobe_hi", 128'(frame_strobe), 128'(1) << 45);
        rst = 1'b1;
        #1;
        check("mid_rst_strobe", 128'(frame_strobe), 128'(0));
        check("mid_rst_data",   128'(frame_data), 128'(0));
        check("mid_rst_fw",     128'(fw), 128'(0));
        check("mid_rst_ready",  128'(wif.WordReady), 128'(1));
        check("mid_rst_busy",   128'(busy), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        idle(1);

`ifdef CFG_FRAME_CHECKSUM_EN
        send(SYNC);
        rand_rows();
        send_frame(32'h1010_2000, 0);
        wif.WordValid = 1'b0;
        check("chk_bad_err",    128'(err), 128'(1));
        check("chk_bad_strobe", 128'(frame_strobe), 128'(0));
        check("chk_bad_synced", 128'(synced), 128'(1));
        idle(3);
        check("chk_bad_fw", 128'(fw), 128'(0));
        rand_rows();
        send_frame(32'h1010_2000, 1);
        wif.WordValid = 1'b0;
        check("chk_good_strobe", 128'(frame_strobe), 128'(1) << 22);
        idle(3);
        check("chk_good_fw", 128'(fw), 128'(1));
`endif

        // randomized stream
        send(SYNC);
        for (int it = 0; it < 250; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            case (act)
                0: send(SYNC);
                1, 2, 3, 4: begin
                    rand_rows();
                    send_frame({4'h1, 8'($urandom_range(0, NC-1)), 8'($urandom_range(0, MF-1)),
                                12'($urandom)}, ($urandom_range(0, 3) != 0));
                end
                5: begin
                    logic [31:0] h;
                    int k;
                    h = {4'h1, 8'($urandom_range(0, NC-1)), 8'($urandom_range(0, MF-1)), 12'($urandom)};
                    k = int'($urandom_range(0, 2));
                    if (k == 0) h[31:28] = 4'($urandom_range(2, 14));
                    else if (k == 1) h[27:20] = 8'($urandom_range(NC, 255));
                    else h[19:12] = 8'($urandom_range(MF, 255));
                    send(h);
                end
                6: send({4'hF, 28'($urandom)});
                7: send($urandom);
                default: idle(int'($urandom_range(0, 3)));
            endcase
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end
endmodule
